// File: rtl/dm_store_buffer_if.sv
// Store-request and memory-write channels of the store buffer.
// The slave modport is the buffer's view; master is the core/memory side.
interface dm_store_buffer_if #(
    parameter int ADDR_W = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [1:0]        st_size;
    logic [31:0]       st_data;
    logic              st_misalign;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_byteen;

    modport slave (
        input  st_valid, st_addr, st_size, st_data, mem_ready,
        output st_ready, st_misalign, mem_valid, mem_addr, mem_wdata, mem_byteen
    );

    modport master (
        output st_valid, st_addr, st_size, st_data, mem_ready,
        input  st_ready, st_misalign, mem_valid, mem_addr, mem_wdata, mem_byteen
    );
endinterface

// File: rtl/dm_store_buffer.sv
// Store buffer: aligns stores into byte lanes and queues them for the data-memory write port.
// Latency: a store accepted in cycle N is presented to memory in N+1 at the earliest.
// Backpressure: st_ready = !full regardless of mem_ready; DM_STBUF_MERGE_EN enables coalescing.
module dm_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    dm_store_buffer_if.slave       bus,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdat;
        logic [3:0]        be;
    } entry_t;

    entry_t         mem_q [DEPTH];
    entry_t         mem_d [DEPTH];
    logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;

    entry_t al;
    logic   al_bad;
    logic   full, st_fire, pop, push, merge_hit;

    always_comb begin
        al      = '0;
        al.addr = {bus.st_addr[ADDR_W-1:2], 2'b00};
        al_bad  = 1'b0;
        case (bus.st_size)
            2'b00: begin
                al.be   = 4'b0001 << bus.st_addr[1:0];
                al.wdat = {24'h0, bus.st_data[7:0]} << {bus.st_addr[1:0], 3'b000};
            end
            2'b01: begin
                if (bus.st_addr[0]) begin
                    al_bad = 1'b1;
                end else if (bus.st_addr[1]) begin
                    al.be   = 4'b1100;
                    al.wdat = {bus.st_data[15:0], 16'h0};
                end else begin
                    al.be   = 4'b0011;
                    al.wdat = {16'h0, bus.st_data[15:0]};
                end
            end
            2'b10: begin
                if (bus.st_addr[1:0] != 2'b00) begin
                    al_bad = 1'b1;
                end else begin
                    al.be   = 4'b1111;
                    al.wdat = bus.st_data;
                end
            end
            default: al_bad = 1'b1;
        endcase
    end

    assign full            = (count_q == CW'(DEPTH));
    assign bus.st_ready    = !full;
    assign bus.st_misalign = bus.st_valid && al_bad;
    assign st_fire         = bus.st_valid && !full;
    assign bus.mem_valid   = (count_q != '0);
    assign pop             = bus.mem_valid && bus.mem_ready;

    // Drive zeros when idle so stale entries never show on the write port.
    assign bus.mem_addr   = bus.mem_valid ? mem_q[head_q].addr : '0;
    assign bus.mem_wdata  = bus.mem_valid ? mem_q[head_q].wdat : '0;
    assign bus.mem_byteen = bus.mem_valid ? mem_q[head_q].be   : '0;

`ifdef DM_STBUF_MERGE_EN
    logic [PW-1:0] young_ptr;
    logic          merge;
    assign young_ptr = tail_q - PW'(1);
    // count >= 2 guarantees the youngest entry is not the head being presented.
    assign merge_hit = (count_q >= CW'(2)) && (mem_q[young_ptr].addr == al.addr);
    assign merge     = st_fire && !al_bad && merge_hit;
`else
    assign merge_hit = 1'b0;
`endif

    assign push = st_fire && !al_bad && !merge_hit;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (push) begin
            mem_d[tail_q] = al;
            tail_d        = tail_q + PW'(1);
        end
`ifdef DM_STBUF_MERGE_EN
        if (merge) begin
            for (int i = 0; i < 4; i++) begin
                if (al.be[i]) begin
                    mem_d[young_ptr].wdat[8*i +: 8] = al.wdat[8*i +: 8];
                end
            end
            mem_d[young_ptr].be = mem_q[young_ptr].be | al.be;
        end
`endif
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign empty = (count_q == '0);
    assign count = count_q;
endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Parametrised store buffer between the MEM stage and the data-memory write port. Accepts raw store requests (address, register data, access size), performs byte-lane alignment and byte-enable generation, queues the aligned writes in a FIFO of DEPTH entries, and drains them to memory with a valid/ready handshake. It decouples store issue from memory back-pressure, and exposes `empty` so the core can order loads behind pending stores.

## Interface
- `DEPTH`, 4, number of queue entries; power of two, ≥2
- `ADDR_W`, 32, byte-address width
- `clk` input 1 — single clock, all state on rising edge
- `reset` input 1 — synchronous, active-high
- `st_valid` input 1 — store request present
- `st_ready` output 1 — buffer can accept; `= !full`, independent of `mem_ready`
- `st_addr` input ADDR_W — byte address
- `st_size` input 2 — 00 byte, 01 half, 10 word, 11 illegal
- `st_data` input 32 — unaligned register data (byte in [7:0], half in [15:0])
- `st_misalign` output 1 — combinational; high when `st_valid` and request is misaligned or illegal
- `mem_valid` output 1 — head entry presented to memory
- `mem_ready` input 1 — memory accepts head this cycle
- `mem_addr` output ADDR_W — word address, `[1:0]` forced 00
- `mem_wdata` output 32 — lane-aligned data, disabled lanes zero
- `mem_byteen` output 4 — byte enables
- `empty` output 1 — no entries queued
- `count` output $clog2(DEPTH)+1 — occupancy

## Operation
- Store fire: `st_valid && st_ready`. Drain fire: `mem_valid && mem_ready`.
- Alignment, `a = st_addr[1:0]`:
  - byte: byteen `4'b0001 << a`, data byte placed in lane a
  - half: a=00 → 0011, data[15:0] in [15:0]; a=10 → 1100, data[15:0] in [31:16]; a odd → misaligned
  - word: a=00 → 1111, data unchanged; else misaligned
  - size 11 → illegal, treated as misaligned
- Misaligned/illegal fire: handshake completes, nothing enqueued, no state change; `st_misalign` reports it for the exception logic.
- Legal fire enqueues {word addr, aligned data, byteen} at tail; drain fire pops head.
- Simultaneous store and drain fire: both occur, count unchanged. When full, `st_ready`=0 even if `mem_ready`=1 that cycle.
- Head/tail pointers wrap modulo DEPTH; full when count==DEPTH.
- `mem_valid = !empty`; head fields stable while `mem_valid && !mem_ready`.
- FIFO order strictly preserved; entries are never reordered or dropped.

## Timing
- Reset: count 0, pointers 0, `empty`=1, `mem_valid`=0, `mem_addr`/`mem_wdata`/`mem_byteen` = 0, `st_ready`=1. Reset mid-operation discards all entries; outputs at reset values the following cycle.
- Latency: store fired in cycle N appears on `mem_valid` in N+1 at earliest (no bypass).
- Throughput: one store and one drain per cycle.
- `st_ready`, `st_misalign`, `empty`, `count` do not depend combinationally on `mem_ready`.

## Configuration
- `DM_STBUF_MERGE_EN` defined: a legal store whose word address equals the youngest entry's address, with that entry not the head (count ≥2, or count==1 and it is not the presented head — i.e. never merge into the head), is coalesced: byteen ORed, new lanes overwrite old; count unchanged. Merge still requires `st_ready`=1. If a drain pops the head in the same cycle and the youngest is the new head, merge still applies (head selection is by pointer before the update).
- Undefined: no coalescing; every legal store occupies its own entry.

## Test plan
- Reset, then sb 0xAB to 0x1003 → next cycle `mem_valid`=1, `mem_addr`=0x1000, `mem_byteen`=1000, `mem_wdata`=0xAB000000.
- sh 0x1234 to 0x2001 → `st_misalign`=1 in the same cycle, `count` stays 0, `mem_valid` stays 0.
- `mem_ready`=0, issue DEPTH word stores → `count`=DEPTH, `st_ready`=0; raise `mem_ready` → drained in order, one per cycle, `empty`=1 after DEPTH cycles.
- Full buffer with `mem_ready`=1 and `st_valid`=1 → no store accepted that cycle; accepted next cycle, count returns to DEPTH.
- With merge: hold `mem_ready`=0, sw 0x11111111 to 0x100, then sb 0x22 to 0x300, then sb 0x22 to 0x301 → count 2, second entry byteen 0011, wdata 0x00002222; without macro count 3.
- Assert `reset` with 3 entries queued → next cycle `empty`=1, `mem_valid`=0, `count`=0.
